// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator cabin controller and its timer.
package elevador_pkg;

  localparam int unsigned ANDAR_W            = 4;
  localparam int unsigned TEMPO_W            = 8;
  localparam int unsigned TEMPO_ANDAR_PADRAO = 8;
  localparam int unsigned TEMPO_PORTA_PADRAO = 16;
  localparam int unsigned N_ANDARES_PADRAO   = 16;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

endpackage

// File: rtl/contador_tempo.sv
// Cycle timer: counts 0..limite-1 while conta is high, restarting at 0 after fim.
module contador_tempo
  import elevador_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               zera,
  input  logic               conta,
  input  logic [TEMPO_W-1:0] limite,
  output logic               fim
);

  logic [TEMPO_W-1:0] contagem;

  // Terminal count decode of the registered count
  assign fim = (contagem == TEMPO_W'(limite - TEMPO_W'(1)));

  // Count register: clear has priority, wraps to 0 on terminal count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= fim ? '0 : contagem + TEMPO_W'(1);
    end
  end

endmodule

// File: rtl/controle_cabine.sv
// Elevator cabin control FSM: travels floor by floor to the head of the stop
// queue, opens the door on arrival and pops rejected or served entries.
module controle_cabine
  import elevador_pkg::*;
#(
  parameter int unsigned TEMPO_ANDAR = TEMPO_ANDAR_PADRAO,
  parameter int unsigned TEMPO_PORTA = TEMPO_PORTA_PADRAO,
  parameter int unsigned N_ANDARES   = N_ANDARES_PADRAO
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ANDAR_W-1:0] proxParada,
  input  logic               pedidoValido,
  output logic [ANDAR_W-1:0] andarAtual,
  output logic               elevador_subindo,
  output logic               chegouParada,
  output logic               portaAberta,
  output logic               motorAtivo,
  output logic               erroPedido
);

  localparam logic [ANDAR_W-1:0] ANDAR_MAX = ANDAR_W'(N_ANDARES - 1);

  estado_t            estado;
  estado_t            estado_prox;
  logic [ANDAR_W-1:0] andar_prox;
  logic [ANDAR_W-1:0] andar_passo;
  logic               subindo_prox;
  logic               chegou_prox;
  logic               erro_prox;
  logic               prox_valida;
  logic               alvo_adiante;
  logic               zera;
  logic               conta;
  logic               fim;
  logic [TEMPO_W-1:0] limite;

  // Door and travel share one timer; the limit follows the current state
  assign limite = (estado == PORTA) ? TEMPO_W'(TEMPO_PORTA) : TEMPO_W'(TEMPO_ANDAR);

  contador_tempo u_contador_tempo (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (zera),
    .conta   (conta),
    .limite  (limite),
    .fim     (fim)
  );

  // Next-state, next-floor and pulse decisions
  always_comb begin
    estado_prox  = estado;
    andar_prox   = andarAtual;
    subindo_prox = elevador_subindo;
    chegou_prox  = 1'b0;
    erro_prox    = 1'b0;
    zera         = 1'b0;
    conta        = 1'b0;
    prox_valida  = (32'(proxParada) < N_ANDARES);

    // Saturating one-floor step in the current travel direction
    if (estado == DESCENDO) begin
      andar_passo  = (andarAtual == '0) ? andarAtual : andarAtual - ANDAR_W'(1);
      alvo_adiante = (proxParada < andar_passo);
    end else begin
      andar_passo  = (andarAtual == ANDAR_MAX) ? andarAtual : andarAtual + ANDAR_W'(1);
      alvo_adiante = (proxParada > andar_passo);
    end

    case (estado)
      PARADO: begin
        zera = 1'b1;
        // While chegouParada is out the queue head is being popped: wait for the next entry
        if (pedidoValido && !chegouParada) begin
          if (!prox_valida) begin
            chegou_prox = 1'b1;
            erro_prox   = 1'b1;
          end else if (proxParada > andarAtual) begin
            estado_prox  = SUBINDO;
            subindo_prox = 1'b1;
          end else if (proxParada < andarAtual) begin
            estado_prox  = DESCENDO;
            subindo_prox = 1'b0;
          end else begin
            estado_prox = PORTA;
            chegou_prox = 1'b1;
          end
        end
      end
      SUBINDO, DESCENDO: begin
        conta = 1'b1;
        // The target is only re-examined when a floor is reached
        if (fim) begin
          andar_prox = andar_passo;
          if (!pedidoValido || !prox_valida) begin
            estado_prox = PARADO;
          end else if (proxParada == andar_passo) begin
            estado_prox = PORTA;
            chegou_prox = 1'b1;
          end else if (!alvo_adiante) begin
            estado_prox = PARADO;
          end
        end
      end
      PORTA: begin
        conta = 1'b1;
        if (fim) begin
          estado_prox = PARADO;
        end
      end
      default: begin
        estado_prox = PARADO;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado           <= PARADO;
      andarAtual       <= '0;
      elevador_subindo <= 1'b0;
      chegouParada     <= 1'b0;
      portaAberta      <= 1'b0;
      motorAtivo       <= 1'b0;
      erroPedido       <= 1'b0;
    end else begin
      estado           <= estado_prox;
      andarAtual       <= andar_prox;
      elevador_subindo <= subindo_prox;
      chegouParada     <= chegou_prox;
      portaAberta      <= (estado_prox == PORTA);
      motorAtivo       <= (estado_prox == SUBINDO) || (estado_prox == DESCENDO);
      erroPedido       <= erro_prox;
    end
  end

endmodule

// File: tb/tb_controle_cabine.sv
// Randomized bench for controle_cabine: a stop queue drives the cabin and a
// trip-level model (floor, remaining cycles, queue head) predicts every output.
module tb_controle_cabine;

  localparam int TA = 8;
  localparam int TP = 16;
  localparam int NA = 8;
  localparam int NCYC = 20000;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] proxParada;
  logic       pedidoValido;
  logic [3:0] andarAtual;
  logic       elevador_subindo;
  logic       chegouParada;
  logic       portaAberta;
  logic       motorAtivo;
  logic       erroPedido;

  int n_checks;
  int n_pass;

  int q[$];
  bit pop_pend;

  int m_floor;
  int m_mode;
  int m_dir;
  int m_left;
  bit m_up;
  bit m_chegou;
  bit m_erro;

  controle_cabine #(
    .TEMPO_ANDAR (TA),
    .TEMPO_PORTA (TP),
    .N_ANDARES   (NA)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .proxParada       (proxParada),
    .pedidoValido     (pedidoValido),
    .andarAtual       (andarAtual),
    .elevador_subindo (elevador_subindo),
    .chegouParada     (chegouParada),
    .portaAberta      (portaAberta),
    .motorAtivo       (motorAtivo),
    .erroPedido       (erroPedido)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_floor  = 0;
    m_mode   = M_IDLE;
    m_dir    = 0;
    m_left   = 0;
    m_up     = 1'b0;
    m_chegou = 1'b0;
    m_erro   = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge
  task automatic model_step(input int prox, input bit valid);
    bit popping;
    popping  = m_chegou;
    m_chegou = 1'b0;
    m_erro   = 1'b0;
    if (m_mode == M_IDLE) begin
      // A new head is only considered once the previous one has been popped
      if (valid && !popping) begin
        if (prox >= NA) begin
          m_chegou = 1'b1;
          m_erro   = 1'b1;
        end else if (prox == m_floor) begin
          m_mode   = M_DOOR;
          m_left   = TP;
          m_chegou = 1'b1;
        end else begin
          m_mode = M_MOVE;
          m_dir  = (prox > m_floor) ? 1 : -1;
          m_up   = (m_dir > 0);
          m_left = TA;
        end
      end
    end else if (m_mode == M_MOVE) begin
      m_left--;
      if (m_left == 0) begin
        m_floor = m_floor + m_dir;
        if (m_floor < 0) m_floor = 0;
        if (m_floor > NA - 1) m_floor = NA - 1;
        m_left = TA;
        if (!valid || prox >= NA) begin
          m_mode = M_IDLE;
        end else if (prox == m_floor) begin
          m_mode   = M_DOOR;
          m_left   = TP;
          m_chegou = 1'b1;
        end else if ((prox - m_floor) * m_dir < 0) begin
          m_mode = M_IDLE;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = M_IDLE;
    end
  endtask

  task automatic check_outputs();
    check("andarAtual", 8'(andarAtual), 8'(m_floor));
    check("elevador_subindo", 8'(elevador_subindo), 8'(m_up));
    check("chegouParada", 8'(chegouParada), 8'(m_chegou));
    check("portaAberta", 8'(portaAberta), 8'(m_mode == M_DOOR));
    check("motorAtivo", 8'(motorAtivo), 8'(m_mode == M_MOVE));
    check("erroPedido", 8'(erroPedido), 8'(m_erro));
  endtask

  task automatic check_all_zero(input string tag);
    logic [7:0] v;
    v = {2'b00, andarAtual == 4'd0 ? 1'b0 : 1'b1, elevador_subindo, chegouParada,
         portaAberta, motorAtivo, erroPedido};
    check(tag, v, 8'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset_n      = 1'b0;
    pedidoValido = 1'b0;
    proxParada   = 4'd0;
    pop_pend     = 1'b0;
    model_reset();
    // Up-trip, down-trip, same floor, out of range, then another up-trip
    q = '{4, 1, 1, 9, 6};

    repeat (2) @(negedge clock);
    check_all_zero("reset_state");
    reset_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Occasional asynchronous reset, usually in the middle of a trip or door
      if (cyc > 100 && $urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        q.delete();
        pop_pend     = 1'b0;
        pedidoValido = 1'b0;
        @(negedge clock);
        check_all_zero("held_reset");
        reset_n = 1'b1;
      end

      check_outputs();

      // The datapath pops its head on the edge that ends the arrival pulse
      if (pop_pend && q.size() > 0) void'(q.pop_front());
      pop_pend = m_chegou;

      if (q.size() < 4 && $urandom_range(0, 5) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 1) q.push_back($urandom_range(NA, 15));
        else if (r < 3) q.push_back(m_floor);
        else q.push_back($urandom_range(0, NA - 1));
      end
      if (q.size() > 0 && m_mode == M_MOVE && $urandom_range(0, 39) == 0) begin
        q[0] = $urandom_range(0, NA - 1);
      end
      if ($urandom_range(0, 499) == 0) q.delete();

      pedidoValido = (q.size() != 0);
      proxParada   = (q.size() != 0) ? 4'(q[0]) : 4'($urandom_range(0, 15));

      model_step(int'(proxParada), pedidoValido);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_cabine.md
CONTROLE_CABINE -- requirements
Module: controle_cabine

Interface
REQ-001 The block SHALL have parameter TEMPO_ANDAR, default 8: clock cycles to travel one floor (legal range 1..255).
REQ-002 The block SHALL have parameter TEMPO_PORTA, default 16: clock cycles the door stays open (legal range 1..255).
REQ-003 The block SHALL have parameter N_ANDARES, default 16: number of floors (legal range 2..16).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  input  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 proxParada  input  4  next stop requested by the datapath's stop queue.
REQ-008 pedidoValido  input  1  proxParada is meaningful (stop queue not empty).
REQ-009 andarAtual  output  4  current cabin floor, which feeds the datapath.
REQ-010 elevador_subindo  output  1  travel direction: 1 = up, 0 = down or none.
REQ-011 chegouParada  output  1  one-cycle pulse on arrival; the datapath uses it as the queue-pop (shift) strobe.
REQ-012 portaAberta  output  1  door open.
REQ-013 motorAtivo  output  1  cabin moving.
REQ-014 erroPedido  output  1  one-cycle pulse when a request is rejected as out of range.

Function
REQ-015 The block SHALL implement an FSM with four states: PARADO, SUBINDO, DESCENDO and PORTA.
REQ-016 In PARADO with pedidoValido=1 and proxParada<N_ANDARES, the FSM SHALL go next cycle to SUBINDO if proxParada>andarAtual, to DESCENDO if proxParada<andarAtual, or to PORTA if they are equal.
REQ-017 In PARADO with pedidoValido=1 and proxParada>=N_ANDARES, the block SHALL stay in PARADO, pulse erroPedido for 1 cycle and pulse chegouParada in the same cycle so the bad entry is popped.
REQ-018 In SUBINDO or DESCENDO, an 8-bit timer SHALL count from 0 and step andarAtual by +1 or -1 on the cycle the count reaches TEMPO_ANDAR-1, then restart at 0.
REQ-019 On each floor step the block SHALL compare the new floor with the current proxParada: equal gives PORTA; target still ahead gives continued travel; target behind or pedidoValido=0 gives PARADO.
REQ-020 A proxParada change mid-segment SHALL NOT abort the segment in progress; the new value takes effect only at the next floor step.
REQ-021 chegouParada SHALL be high for exactly 1 cycle, in the first cycle of PORTA.
REQ-022 In PORTA the timer SHALL count TEMPO_PORTA cycles, then return to PARADO; portaAberta SHALL be high for exactly TEMPO_PORTA cycles.
REQ-023 andarAtual SHALL saturate at 0 and at N_ANDARES-1, and SHALL never wrap.
REQ-024 motorAtivo SHALL be 1 only in SUBINDO or DESCENDO.
REQ-025 elevador_subindo SHALL be 1 in SUBINDO, 0 in DESCENDO, and SHALL hold its last value in PARADO and PORTA.
REQ-026 All outputs SHALL be registered.
REQ-027 Latency from a valid request to the first floor step SHALL be 1+TEMPO_ANDAR cycles; latency from a same-floor request to chegouParada SHALL be 1 cycle.

Reset
REQ-028 reset_n=0 SHALL, asynchronously and regardless of state, force: state=PARADO, timer=0, andarAtual=0, elevador_subindo=0, chegouParada=0, portaAberta=0, motorAtivo=0, erroPedido=0.
REQ-029 Assertion of reset_n mid-travel or mid-door SHALL abandon the trip; no chegouParada pulse SHALL be emitted.
REQ-030 After reset_n is released, the first state change SHALL occur no earlier than the first rising clock edge.

Structure
REQ-031 The state encoding, default timing constants and the 4-bit floor width SHALL live in shared package elevador_pkg.
REQ-032 The timer SHALL be a sub-module, contador_tempo, with inputs zera and conta and output fim, matching the zeraT/contaT/fimT convention used in the datapath.
REQ-033 The FSM and floor register SHALL reside in controle_cabine itself.

Verification
REQ-034 Scenario up-trip: reset; proxParada=4, pedidoValido=1 -> andarAtual steps 1,2,3,4 every 8 cycles; chegouParada pulses once; portaAberta high 16 cycles; elevador_subindo=1 throughout.
REQ-035 Scenario down-trip: start at floor 4; proxParada=1 -> DESCENDO; andarAtual 3,2,1; elevador_subindo=0; single chegouParada pulse.
REQ-036 Scenario same floor: andarAtual=2, proxParada=2 -> chegouParada 1 cycle after the request; motorAtivo never asserted.
REQ-037 Scenario retarget: heading to 6; proxParada changes to 1 at floor 3 mid-segment -> reaches floor 4, enters PARADO, then DESCENDO to 1.
REQ-038 Scenario out of range with N_ANDARES=8: proxParada=9 -> erroPedido and chegouParada pulse together; andarAtual unchanged.
REQ-039 Scenario reset mid-trip: reset_n pulled low at floor 2 of a trip to 5 -> all outputs 0 immediately, without waiting for a clock edge; no chegouParada pulse.
